// File: rtl/ws2812b_pkg.sv
// Shared definitions for the ws2812b sequencer and its register front-end.
// Holds the sequencer state encoding and the GRB byte-lane offsets.
package ws2812b_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } ws_state_t;

  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

endpackage

// File: rtl/ws2812b_seg_table.sv
// Segment table: SEGMENTS entries of {GRB color, run length}, one write port.
// Reads entry rd_idx, the length of the entry after it, and the length of entry 0.
module ws2812b_seg_table #(
  parameter int SEGMENTS = 4,
  parameter int COUNT_W  = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [$clog2(SEGMENTS)-1:0] widx,
  input  logic [23:0]                 wcolor,
  input  logic [COUNT_W-1:0]          wlen,
  input  logic [$clog2(SEGMENTS)-1:0] rd_idx,
  output logic [23:0]                 rd_color,
  output logic [COUNT_W-1:0]          nxt_len,
  output logic [COUNT_W-1:0]          head_len
);

  localparam int IDX_W = $clog2(SEGMENTS);

  logic [23:0]        color_q [SEGMENTS];
  logic [COUNT_W-1:0] len_q   [SEGMENTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SEGMENTS; i++) begin
        color_q[i] <= '0;
        len_q[i]   <= '0;
      end
    end else if (we) begin
      color_q[widx] <= wcolor;
      len_q[widx]   <= wlen;
    end
  end

  assign rd_color = color_q[rd_idx];
  assign head_len = len_q[0];
  // Past the last entry the list is implicitly terminated.
  assign nxt_len  = (rd_idx == IDX_W'(SEGMENTS - 1)) ? '0 : len_q[rd_idx + IDX_W'(1)];

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Walks the segment table and hands one pixel at a time to the ws2812b serializer,
// optionally repeating the frame after a programmable gap.
module ws2812b_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int SEGMENTS = 4,
  parameter int COUNT_W  = 6,
  parameter int PERIOD_W = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        seg_we,
  input  logic [$clog2(SEGMENTS)-1:0] seg_idx,
  input  logic [23:0]                 seg_color,
  input  logic [COUNT_W-1:0]          seg_len,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        repeat_en,
  input  logic [PERIOD_W-1:0]         period,
  output logic                        busy,
  output logic                        frame_done,
  output logic [23:0]                 ws_data,
  output logic                        ws_valid,
  output logic                        ws_latch,
  input  logic                        ws_ready
);

  localparam int IDX_W = $clog2(SEGMENTS);

  ws_state_t           state, state_n;
  logic [IDX_W-1:0]    seg, seg_n;
  logic [COUNT_W-1:0]  rem, rem_n;
  logic [PERIOD_W-1:0] gap_cnt, gap_n;
  logic [PERIOD_W-1:0] per_q, per_n;
  logic                rep_q, rep_n;
  logic                stop_pend, stop_n;
  logic [23:0]         data_n;
  logic                valid_n, latch_n, busy_n, done_n;
  logic                tbl_we;
  logic [23:0]         cur_color;
  logic [COUNT_W-1:0]  nxt_len, head_len;

  ws2812b_seg_table #(.SEGMENTS(SEGMENTS), .COUNT_W(COUNT_W)) u_tbl (
    .clk      (clk),
    .reset    (reset),
    .we       (tbl_we),
    .widx     (seg_idx),
    .wcolor   (seg_color),
    .wlen     (seg_len),
    .rd_idx   (seg),
    .rd_color (cur_color),
    .nxt_len  (nxt_len),
    .head_len (head_len)
  );

  always_comb begin
    state_n = state;
    seg_n   = seg;
    rem_n   = rem;
    gap_n   = gap_cnt;
    per_n   = per_q;
    rep_n   = rep_q;
    stop_n  = stop_pend;
    data_n  = ws_data;
    valid_n = ws_valid;
    latch_n = ws_latch;
    tbl_we  = 1'b0;
    if (busy && stop) stop_n = 1'b1;
    unique case (state)
      ST_IDLE: begin
        tbl_we = seg_we;
        if (start && (head_len != '0)) begin
          rep_n   = repeat_en;
          per_n   = period;
          seg_n   = '0;
          rem_n   = head_len;
          stop_n  = stop;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ws_ready) begin
          valid_n = 1'b1;
          data_n  = cur_color;
          latch_n = (rem == COUNT_W'(1)) && (nxt_len == '0);
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!ws_ready) begin
          valid_n = 1'b0;
          latch_n = 1'b0;
          if (rem > COUNT_W'(1)) begin
            rem_n   = rem - COUNT_W'(1);
            state_n = ST_ISSUE;
          end else if (nxt_len != '0) begin
            seg_n   = seg + IDX_W'(1);
            rem_n   = nxt_len;
            state_n = ST_ISSUE;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A zero period skips GAP so the next frame starts right away.
        if (rep_q && !stop_pend && !stop) begin
          if (per_q != '0) begin
            gap_n   = per_q;
            state_n = ST_GAP;
          end else if (head_len == '0) begin
            state_n = ST_IDLE;
          end else begin
            seg_n   = '0;
            rem_n   = head_len;
            state_n = ST_ISSUE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        tbl_we = seg_we;
        if (stop_pend || stop) begin
          state_n = ST_IDLE;
        end else if (gap_cnt != '0) begin
          gap_n = gap_cnt - PERIOD_W'(1);
        end else if (head_len == '0) begin
          state_n = ST_IDLE;
        end else begin
          seg_n   = '0;
          rem_n   = head_len;
          state_n = ST_ISSUE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      seg        <= '0;
      rem        <= '0;
      gap_cnt    <= '0;
      per_q      <= '0;
      rep_q      <= 1'b0;
      stop_pend  <= 1'b0;
      ws_data    <= '0;
      ws_valid   <= 1'b0;
      ws_latch   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      seg        <= seg_n;
      rem        <= rem_n;
      gap_cnt    <= gap_n;
      per_q      <= per_n;
      rep_q      <= rep_n;
      stop_pend  <= stop_n;
      ws_data    <= data_n;
      ws_valid   <= valid_n;
      ws_latch   <= latch_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Directed bench for ws2812b_frame_sequencer with a frame-level pixel model
// and a per-cycle handshake/pixel checker.
module tb_ws2812b_frame_sequencer;

  localparam int SEGMENTS = 4;
  localparam int COUNT_W  = 6;
  localparam int PERIOD_W = 20;

  logic                clk;
  logic                reset;
  logic                seg_we;
  logic [1:0]          seg_idx;
  logic [23:0]         seg_color;
  logic [COUNT_W-1:0]  seg_len;
  logic                start, stop, repeat_en;
  logic [PERIOD_W-1:0] period;
  logic                busy, frame_done, ws_valid, ws_latch;
  logic [23:0]         ws_data;
  logic                ws_ready = 1'b1;

  ws2812b_frame_sequencer #(.SEGMENTS(SEGMENTS), .COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .reset(reset), .seg_we(seg_we), .seg_idx(seg_idx), .seg_color(seg_color),
    .seg_len(seg_len), .start(start), .stop(stop), .repeat_en(repeat_en), .period(period),
    .busy(busy), .frame_done(frame_done), .ws_data(ws_data), .ws_valid(ws_valid),
    .ws_latch(ws_latch), .ws_ready(ws_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_true(input string nm, input bit cond);
    n_checks++;
    if (!cond) begin
      n_errors++;
      $display("FAIL %s: condition false, expected true", nm);
    end
  endtask

  // Frame model: the pixel stream a frame must produce, built from the table contents.
  typedef struct { logic [23:0] c; logic l; } px_t;
  px_t exp_q[$];
  logic [23:0]        sh_color [SEGMENTS];
  logic [COUNT_W-1:0] sh_len   [SEGMENTS];

  function automatic void push_frame();
    px_t fr[$];
    px_t p;
    for (int i = 0; i < SEGMENTS; i++) begin
      if (sh_len[i] == 0) break;
      for (int j = 0; j < int'(sh_len[i]); j++) begin
        p.c = sh_color[i];
        p.l = 1'b0;
        fr.push_back(p);
      end
    end
    if (fr.size() > 0) fr[fr.size()-1].l = 1'b1;
    foreach (fr[k]) exp_q.push_back(fr[k]);
  endfunction

  // Ready model: auto mode drops ready one cycle after valid and re-raises it 10 cycles later.
  bit rdy_auto   = 1'b1;
  bit rdy_manual = 1'b1;
  int rdy_low    = 0;
  always @(posedge clk) begin
    #2;
    if (!rdy_auto) ws_ready = rdy_manual;
    else if (rdy_low > 0) begin
      rdy_low--;
      if (rdy_low == 0) ws_ready = 1'b1;
    end else if (ws_valid && ws_ready) begin
      ws_ready = 1'b0;
      rdy_low  = 10;
    end else ws_ready = 1'b1;
  end

  // Per-cycle checker.
  int          pix_cnt = 0, latch_cnt = 0, frames = 0;
  logic [23:0] last_px_data = '0;
  bit          last_latch = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b1, prev_latch = 1'b0, prev_done = 1'b0;
  logic        prev_reset = 1'b1;
  logic [23:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset || prev_reset) begin
      exp_q.delete();
    end else begin
      if (ws_valid && !prev_valid) begin
        px_t e;
        expect_true("rise_after_ready_high", prev_ready);
        expect_true("pixel_expected", exp_q.size() > 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("px_data", 32'(ws_data), 32'(e.c));
          chk("px_latch", 32'(ws_latch), 32'(e.l));
        end
        pix_cnt++;
        if (ws_latch) latch_cnt++;
        last_px_data = ws_data;
        last_latch   = ws_latch;
      end else if (ws_valid && prev_valid) begin
        expect_true("valid_kept_only_while_ready", prev_ready);
        chk("data_stable", 32'(ws_data), 32'(prev_data));
        chk("latch_stable", 32'(ws_latch), 32'(prev_latch));
      end else if (!ws_valid && prev_valid) begin
        expect_true("fall_after_ready_low", !prev_ready);
      end
      if (frame_done) begin
        expect_true("done_after_latched_pixel", last_latch);
        expect_true("done_single_cycle", !prev_done);
        frames++;
        last_latch = 1'b0;
      end
      expect_true("latch_only_with_valid", !ws_latch || ws_valid);
    end
    prev_reset = reset;
    prev_valid = ws_valid;
    prev_ready = ws_ready;
    prev_latch = ws_latch;
    prev_data  = ws_data;
    prev_done  = frame_done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_seg(input int idx, input logic [23:0] c, input int len, input bit apply);
    seg_we = 1'b1; seg_idx = 2'(idx); seg_color = c; seg_len = COUNT_W'(len);
    tick(1);
    seg_we = 1'b0;
    if (apply) begin
      sh_color[idx] = c;
      sh_len[idx]   = COUNT_W'(len);
    end
  endtask

  task automatic start_frame(input bit rep, input int per);
    repeat_en = rep; period = PERIOD_W'(per); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic stop_frame();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    expect_true({nm, "_idle_in_time"}, n < budget);
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    while (!ws_valid && n < budget) begin tick(1); n++; end
    expect_true({nm, "_valid_in_time"}, n < budget);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!frame_done && n < budget) begin tick(1); n++; end
    expect_true({nm, "_done_in_time"}, n < budget);
  endtask

  int p0, f0, l0, cnt, d_cyc, v_cyc;

  initial begin
    reset = 1'b1; seg_we = 1'b0; seg_idx = '0; seg_color = '0; seg_len = '0;
    start = 1'b0; stop = 1'b0; repeat_en = 1'b0; period = '0;
    for (int i = 0; i < SEGMENTS; i++) begin sh_color[i] = '0; sh_len[i] = '0; end
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(ws_valid), 0);
    chk("rst_latch", 32'(ws_latch), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_data", 32'(ws_data), 0);
    reset = 1'b0;
    tick(2);

    // Single segment of 3 LEDs.
    write_seg(0, 24'h102030, 3, 1);
    write_seg(1, 24'h0, 0, 1);
    push_frame();
    p0 = pix_cnt; f0 = frames; l0 = latch_cnt;
    start_frame(0, 0);
    chk("t1_busy_after_start", 32'(busy), 1);
    tick(1);
    chk("t1_valid_two_after_start", 32'(ws_valid), 1);
    chk("t1_first_data", 32'(ws_data), 32'h102030);
    wait_idle(300, "t1");
    tick(2);
    chk("t1_pixels", 32'(pix_cnt - p0), 3);
    chk("t1_latches", 32'(latch_cnt - l0), 1);
    chk("t1_frames", 32'(frames - f0), 1);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_model_drained", 32'(exp_q.size()), 0);

    // Two segments.
    write_seg(0, 24'hFF0000, 2, 1);
    write_seg(1, 24'h0000FF, 1, 1);
    push_frame();
    p0 = pix_cnt; l0 = latch_cnt;
    start_frame(0, 0);
    wait_idle(300, "t2");
    tick(2);
    chk("t2_pixels", 32'(pix_cnt - p0), 3);
    chk("t2_last_data", 32'(last_px_data), 32'h0000FF);
    chk("t2_latches", 32'(latch_cnt - l0), 1);

    // Ready held low at start.
    rdy_manual = 1'b0; rdy_auto = 1'b0;
    tick(2);
    push_frame();
    p0 = pix_cnt;
    start_frame(0, 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (ws_valid) cnt++;
      tick(1);
    end
    chk("t3_no_valid_while_not_ready", 32'(cnt), 0);
    chk("t3_busy_waiting", 32'(busy), 1);
    rdy_manual = 1'b1;
    tick(2);
    chk("t3_valid_after_ready", 32'(ws_valid), 1);
    tick(5);
    chk("t3_valid_held", 32'(ws_valid), 1);
    chk("t3_data_held", 32'(ws_data), 32'hFF0000);
    rdy_manual = 1'b0;
    tick(2);
    chk("t3_valid_drop", 32'(ws_valid), 0);
    rdy_manual = 1'b1;
    tick(1);
    rdy_auto = 1'b1;
    wait_idle(300, "t3");
    tick(2);
    chk("t3_pixels", 32'(pix_cnt - p0), 3);

    // Repeat with gap, stopped during the second frame.
    write_seg(0, 24'h0A0B0C, 2, 1);
    write_seg(1, 24'h0, 0, 1);
    push_frame(); push_frame();
    p0 = pix_cnt; f0 = frames;
    start_frame(1, 100);
    wait_done(300, "t4");
    d_cyc = cyc;
    wait_valid(400, "t4");
    v_cyc = cyc;
    expect_true("t4_gap_at_least_period_plus_1", (v_cyc - d_cyc) >= 101);
    stop_frame();
    wait_idle(400, "t4");
    tick(150);
    chk("t4_pixels", 32'(pix_cnt - p0), 4);
    chk("t4_frames", 32'(frames - f0), 2);
    chk("t4_busy_after", 32'(busy), 0);
    chk("t4_model_drained", 32'(exp_q.size()), 0);

    // Table write during HOLD is ignored.
    write_seg(0, 24'h112233, 2, 1);
    push_frame();
    start_frame(0, 0);
    wait_valid(50, "t5a");
    write_seg(0, 24'h00FF00, 2, 0);
    wait_idle(300, "t5a");
    tick(2);
    chk("t5a_old_color_kept", 32'(last_px_data), 32'h112233);

    // Table write during GAP is used by the next frame.
    push_frame();
    p0 = pix_cnt; f0 = frames;
    start_frame(1, 100);
    wait_done(300, "t5b");
    tick(5);
    write_seg(0, 24'h00FF00, 2, 1);
    push_frame();
    wait_valid(400, "t5b");
    chk("t5b_new_color_used", 32'(ws_data), 32'h00FF00);
    stop_frame();
    wait_idle(400, "t5b");
    tick(2);
    chk("t5b_pixels", 32'(pix_cnt - p0), 4);
    chk("t5b_frames", 32'(frames - f0), 2);

    // Empty table: start is ignored.
    write_seg(0, 24'h00FF00, 0, 1);
    p0 = pix_cnt;
    start_frame(1, 5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) cnt++;
      tick(1);
    end
    chk("t5c_busy_never", 32'(cnt), 0);
    chk("t5c_no_pixels", 32'(pix_cnt - p0), 0);

    // Reset mid-frame.
    rdy_auto = 1'b0; rdy_manual = 1'b1;
    tick(2);
    write_seg(0, 24'h445566, 5, 1);
    push_frame();
    start_frame(0, 0);
    wait_valid(50, "t6");
    reset = 1'b1;
    tick(1);
    chk("t6_valid_reset", 32'(ws_valid), 0);
    chk("t6_latch_reset", 32'(ws_latch), 0);
    chk("t6_busy_reset", 32'(busy), 0);
    chk("t6_data_reset", 32'(ws_data), 0);
    reset = 1'b0;
    for (int i = 0; i < SEGMENTS; i++) begin sh_color[i] = '0; sh_len[i] = '0; end
    tick(2);
    p0 = pix_cnt;
    start_frame(0, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || ws_valid) cnt++;
      tick(1);
    end
    chk("t6_start_ignored_after_reset", 32'(cnt), 0);
    chk("t6_no_pixels", 32'(pix_cnt - p0), 0);
    rdy_auto = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
